qspi_bus_arbiter: RTL and testbench

Shares tinyQV's single QSPI bus (flash on select 0, PSRAM A/B on selects 6/7) between the instruction-fetch port and the data load/store port. Accepts one request at a time and sequences the full quad transaction: select, command, address, dummy, data and deselect. Drives the QSPI pins at clk/2 and applies the read-capture latency strapped on the data pins during reset. Sits between the CPU core's memory ports and the `uio` pad mapping at the top level.

---
 rtl/qspi_bus_arbiter_if.sv | 39 +++
 rtl/qspi_bus_arbiter.sv | 127 ++++++++++++
 tb/tb_qspi_bus_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qspi_bus_arbiter_if.sv
// qspi_bus_arbiter_if: CPU memory ports and QSPI pad signals around the bus arbiter
interface qspi_bus_arbiter_if;
    logic [2:0]  latency_cfg;
    logic        instr_req;
    logic [24:0] instr_addr;
    logic        instr_done;
    logic [15:0] instr_rdata;
    logic        data_req;
    logic        data_write;
    logic [24:0] data_addr;
    logic [1:0]  data_len;
    logic [31:0] data_wdata;
    logic        data_done;
    logic        data_err;
    logic [31:0] data_rdata;
    logic        qspi_clk_out;
    logic [3:0]  qspi_data_out;
    logic [3:0]  qspi_data_oe;
    logic [3:0]  qspi_data_in;
    logic        qspi_flash_select;
    logic        qspi_ram_a_select;
    logic        qspi_ram_b_select;

    modport master (
        output latency_cfg, instr_req, instr_addr, data_req, data_write, data_addr,
               data_len, data_wdata, qspi_data_in,
        input  instr_done, instr_rdata, data_done, data_err, data_rdata, qspi_clk_out,
               qspi_data_out, qspi_data_oe, qspi_flash_select, qspi_ram_a_select,
               qspi_ram_b_select
    );

    modport slave (
        input  latency_cfg, instr_req, instr_addr, data_req, data_write, data_addr,
               data_len, data_wdata, qspi_data_in,
        output instr_done, instr_rdata, data_done, data_err, data_rdata, qspi_clk_out,
               qspi_data_out, qspi_data_oe, qspi_flash_select, qspi_ram_a_select,
               qspi_ram_b_select
    );
endinterface

// File: rtl/qspi_bus_arbiter.sv
// qspi_bus_arbiter: shares the QSPI bus between fetch and data ports; define QSPI_ARB_ROUND_ROBIN_EN for round-robin ties
module qspi_bus_arbiter (
    input  logic              clk,
    input  logic              rst_n,
    qspi_bus_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, DESEL, ERR} state_t;

    state_t      state, state_nx;
    logic [5:0]  cnt;
    logic [2:0]  lat;
    logic        owner;
    logic        wr;
    logic [24:0] addr;
    logic [1:0]  len;
    logic [31:0] wdata;
    logic [31:0] rbuf;
    logic        arb, take, pick_data, cap, active, done;
    logic [5:0]  last;
    logic [3:0]  d;
    logic [7:0]  cmd;

`ifdef QSPI_ARB_ROUND_ROBIN_EN
    logic last_instr;
    assign pick_data = bus.data_req && (!bus.instr_req || last_instr);
    // Remember which port won the latest grant so a tie goes to the other one
    always_ff @(posedge clk)
        if (!rst_n) last_instr <= 1'b1;
        else if (take) last_instr <= !pick_data;
`else
    assign pick_data = bus.data_req;
`endif

    assign arb    = state == IDLE || (state == DESEL && cnt == 6'd1);
    assign take   = arb && (bus.data_req || bus.instr_req);
    assign last   = {2'b00, len, 2'b11} + (wr ? 6'd0 : {3'b000, lat});
    assign d      = cnt[3:0] - {1'b0, lat};
    assign cap    = state == DATA && !wr && cnt > {3'b000, lat} && d[0];
    assign cmd    = wr ? 8'h38 : 8'hEB;
    assign active = state inside {CMD, ADDR, DUMMY, DATA};
    assign done   = (state == DESEL && cnt == 6'd0) || state == ERR;

    assign bus.qspi_flash_select = !(active && !addr[24]);
    assign bus.qspi_ram_a_select = !(active && addr[24:23] == 2'b10);
    assign bus.qspi_ram_b_select = !(active && addr[24:23] == 2'b11);
    assign bus.instr_done        = done && !owner;
    assign bus.instr_rdata       = bus.instr_done ? rbuf[15:0] : 16'h0;
    assign bus.data_done         = done && owner;
    assign bus.data_err          = state == ERR;
    assign bus.data_rdata        = bus.data_done ? rbuf : 32'h0;

    // State, phase counter, latched request and read capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 6'd0;
            lat   <= bus.latency_cfg;
            owner <= 1'b0;
            wr    <= 1'b0;
            addr  <= 25'h0;
            len   <= 2'd0;
            wdata <= 32'h0;
            rbuf  <= 32'h0;
        end else begin
            state <= state_nx;
            cnt   <= state_nx != state ? 6'd0 : cnt + 6'd1;
            if (take) begin
                owner <= pick_data;
                wr    <= pick_data && bus.data_write;
                addr  <= pick_data ? bus.data_addr : bus.instr_addr;
                len   <= pick_data ? bus.data_len : 2'd1;
                wdata <= bus.data_wdata;
                rbuf  <= 32'h0;
            end else if (cap) begin
                rbuf[{d[3:2], ~d[1], 2'b00} +: 4] <= bus.qspi_data_in;
            end
        end
    end

    // Phase sequencing; DESEL's second cycle arbitrates exactly like IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DESEL: if (arb) state_nx = !take ? IDLE :
                                             (pick_data && bus.data_write && !bus.data_addr[24]) ? ERR : CMD;
            CMD:     if (cnt == 6'd3) state_nx = ADDR;
            ADDR:    if (cnt == 6'd11) state_nx = wr ? DATA : DUMMY;
            DUMMY:   if (cnt == 6'd11) state_nx = DATA;
            DATA:    if (cnt == last) state_nx = DESEL;
            default: state_nx = IDLE;
        endcase
    end

    // Pin values for the current nibble; the clock idles low and lines are released outside drive phases
    always_comb begin
        bus.qspi_clk_out  = 1'b0;
        bus.qspi_data_out = 4'h0;
        bus.qspi_data_oe  = 4'h0;
        case (state)
            CMD: begin
                bus.qspi_clk_out  = cnt[0];
                bus.qspi_data_oe  = 4'hF;
                bus.qspi_data_out = cnt[1] ? cmd[3:0] : cmd[7:4];
            end
            ADDR: begin
                bus.qspi_clk_out  = cnt[0];
                bus.qspi_data_oe  = 4'hF;
                bus.qspi_data_out = addr[5'd20 - {cnt[3:1], 2'b00} +: 4];
            end
            DUMMY: begin
                bus.qspi_clk_out = cnt[0];
                if (!addr[24] && cnt < 6'd4) begin
                    bus.qspi_data_oe  = 4'hF;
                    bus.qspi_data_out = 4'hF;
                end
            end
            DATA: begin
                bus.qspi_clk_out = wr ? cnt[0] : cnt[0] && cnt <= {2'b00, len, 2'b11};
                if (wr) begin
                    bus.qspi_data_oe  = 4'hF;
                    bus.qspi_data_out = wdata[{cnt[3:2], ~cnt[1], 2'b00} +: 4];
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_qspi_bus_arbiter.sv
// tb_qspi_bus_arbiter: QSPI device model plus a transaction scoreboard for qspi_bus_arbiter
`timescale 1ns/1ps
module tb_qspi_bus_arbiter;
    typedef struct packed {
        logic        is_data;
        logic        err;
        logic [31:0] rdata;
        logic [7:0]  sel_len;
        logic [1:0]  sel_id;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    qspi_bus_arbiter_if bus();
    qspi_bus_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    txn_t       sb[$];
    txn_t       obs[$];
    logic [3:0] nibs[$];
    logic [3:0] rd_nib [8];
    int         rd_lat = 3;
    int         low_cnt [3];
    int         starts [3];
    int         n_checks = 0;
    int         n_fail = 0;

    // One cycle: observe at the falling edge, model the device's read data, log bus activity
    task automatic tick();
        logic [2:0] low;
        int c, j;
        txn_t o;
        @(negedge clk);
        low = ~{bus.qspi_ram_b_select, bus.qspi_ram_a_select, bus.qspi_flash_select};
        c = low_cnt[0] + low_cnt[1] + low_cnt[2];
        j = c - 29 - rd_lat;
        bus.qspi_data_in = (low != 3'b000 && j >= 0 && j % 2 == 0 && j < 16) ? rd_nib[j/2] : 4'h5;
        o = '0;
        o.sel_id = 2'd3;
        for (int i = 0; i < 3; i++) begin
            if (low[i] === 1'b1) begin
                if (low_cnt[i] == 0) starts[i]++;
                low_cnt[i]++;
            end else if (low_cnt[i] > 0) begin
                o.sel_len = 8'(low_cnt[i]);
                o.sel_id = 2'(i);
                low_cnt[i] = 0;
            end
        end
        if (bus.qspi_clk_out === 1'b1 && bus.qspi_data_oe === 4'hF) nibs.push_back(bus.qspi_data_out);
        if (bus.instr_done === 1'b1 || bus.data_done === 1'b1) begin
            o.is_data = bus.data_done;
            o.err = bus.data_err;
            o.rdata = bus.data_done ? bus.data_rdata : {16'h0, bus.instr_rdata};
            obs.push_back(o);
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            ok = obs.size() > 0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.latency_cfg = 3'd3;
        repeat (3) tick();
        n_checks++;
        if ({bus.qspi_flash_select, bus.qspi_ram_a_select, bus.qspi_ram_b_select} !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_selects: got %b want 111", {bus.qspi_flash_select, bus.qspi_ram_a_select, bus.qspi_ram_b_select});
        end
        n_checks++;
        if ({bus.qspi_clk_out, bus.qspi_data_out, bus.qspi_data_oe} !== 9'h0) begin
            n_fail++;
            $display("FAIL reset_pins: clk=%b out=%h oe=%h want 0", bus.qspi_clk_out, bus.qspi_data_out, bus.qspi_data_oe);
        end
        n_checks++;
        if ({bus.instr_done, bus.data_done, bus.data_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_done: got %b want 000", {bus.instr_done, bus.data_done, bus.data_err});
        end
        n_checks++;
        if ({bus.instr_rdata, bus.data_rdata} !== 48'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h/%h want 0", bus.instr_rdata, bus.data_rdata);
        end
        rst_n = 1'b1;
        bus.latency_cfg = 3'd6;
        tick();
    endtask

    task automatic test_fetch();
        bit ok;
        logic [39:0] pk;
        txn_t e, o;
        repeat (3) tick();
        nibs.delete();
        sb.push_back('{is_data: 1'b0, err: 1'b0, rdata: 32'h3412, sel_len: 8'd39, sel_id: 2'd0});
        bus.instr_addr = 25'h0000100;
        bus.instr_req = 1'b1;
        wait_done(200, ok);
        bus.instr_req = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL fetch_timeout: no instr_done within 200 cycles");
        end else begin
            e = sb.pop_front();
            o = obs.pop_front();
            if (o !== e) begin
                n_fail++;
                $display("FAIL fetch_txn: got data=%b err=%b rdata=%h sel%0d=%0d want data=%b err=%b rdata=%h sel%0d=%0d",
                         o.is_data, o.err, o.rdata, o.sel_id, o.sel_len, e.is_data, e.err, e.rdata, e.sel_id, e.sel_len);
            end
        end
        pk = '0;
        foreach (nibs[i]) pk = {pk[35:0], nibs[i]};
        n_checks++;
        if (nibs.size() != 10 || pk !== 40'hEB000100FF) begin
            n_fail++;
            $display("FAIL fetch_nibbles: got %0d nibbles %h want 10 nibbles eb000100ff", nibs.size(), pk);
        end
    endtask

    task automatic test_drop();
        bit ok;
        txn_t e, o;
        repeat (3) tick();
        sb.push_back('{is_data: 1'b0, err: 1'b0, rdata: 32'h3412, sel_len: 8'd39, sel_id: 2'd0});
        bus.instr_addr = 25'h0000200;
        bus.instr_req = 1'b1;
        repeat (8) tick();
        bus.instr_req = 1'b0;
        wait_done(200, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL drop_timeout: dropped fetch never completed");
        end else begin
            e = sb.pop_front();
            o = obs.pop_front();
            if (o !== e) begin
                n_fail++;
                $display("FAIL drop_txn: got data=%b rdata=%h sel%0d=%0d want data=%b rdata=%h sel%0d=%0d",
                         o.is_data, o.rdata, o.sel_id, o.sel_len, e.is_data, e.rdata, e.sel_id, e.sel_len);
            end
        end
    endtask

    task automatic test_write();
        bit ok;
        logic [63:0] pk;
        txn_t e, o;
        repeat (3) tick();
        nibs.delete();
        sb.push_back('{is_data: 1'b1, err: 1'b0, rdata: 32'h0, sel_len: 8'd32, sel_id: 2'd2});
        bus.data_write = 1'b1;
        bus.data_addr = 25'h1800010;
        bus.data_len = 2'd3;
        bus.data_wdata = 32'hDEADBEEF;
        bus.data_req = 1'b1;
        wait_done(200, ok);
        bus.data_req = 1'b0;
        bus.data_write = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL write_timeout: no data_done within 200 cycles");
        end else begin
            e = sb.pop_front();
            o = obs.pop_front();
            if (o !== e) begin
                n_fail++;
                $display("FAIL write_txn: got data=%b err=%b rdata=%h sel%0d=%0d want data=%b err=%b rdata=%h sel%0d=%0d",
                         o.is_data, o.err, o.rdata, o.sel_id, o.sel_len, e.is_data, e.err, e.rdata, e.sel_id, e.sel_len);
            end
        end
        pk = '0;
        foreach (nibs[i]) pk = {pk[59:0], nibs[i]};
        n_checks++;
        if (nibs.size() != 16 || pk !== 64'h38800010EFBEADDE) begin
            n_fail++;
            $display("FAIL write_nibbles: got %0d nibbles %h want 16 nibbles 38800010efbeadde", nibs.size(), pk);
        end
    endtask

    task automatic test_flash_write();
        int s [3];
        txn_t e, o;
        repeat (3) tick();
        s = starts;
        sb.push_back('{is_data: 1'b1, err: 1'b1, rdata: 32'h0, sel_len: 8'd0, sel_id: 2'd3});
        bus.data_write = 1'b1;
        bus.data_addr = 25'h0000000;
        bus.data_len = 2'd0;
        bus.data_req = 1'b1;
        tick();
        n_checks++;
        if ({bus.data_done, bus.data_err} !== 2'b11) begin
            n_fail++;
            $display("FAIL flash_write_pulse: done/err=%b%b one cycle after request, want 11", bus.data_done, bus.data_err);
        end
        bus.data_req = 1'b0;
        bus.data_write = 1'b0;
        repeat (10) tick();
        n_checks++;
        if (obs.size() != 1) begin
            n_fail++;
            $display("FAIL flash_write_count: got %0d completions want 1", obs.size());
        end else begin
            e = sb.pop_front();
            o = obs.pop_front();
            if (o !== e) begin
                n_fail++;
                $display("FAIL flash_write_txn: got data=%b err=%b sel%0d=%0d want data=%b err=%b sel%0d=%0d",
                         o.is_data, o.err, o.sel_id, o.sel_len, e.is_data, e.err, e.sel_id, e.sel_len);
            end
        end
        n_checks++;
        if (starts != s) begin
            n_fail++;
            $display("FAIL flash_write_selects: select low count %0d/%0d/%0d want %0d/%0d/%0d",
                     starts[0], starts[1], starts[2], s[0], s[1], s[2]);
        end
        obs.delete();
        sb.delete();
    endtask

    task automatic test_tie();
        bit ok;
        txn_t e, o;
        txn_t ed = '{is_data: 1'b1, err: 1'b0, rdata: 32'h12, sel_len: 8'd35, sel_id: 2'd1};
        txn_t ei = '{is_data: 1'b0, err: 1'b0, rdata: 32'h3412, sel_len: 8'd39, sel_id: 2'd0};
        repeat (3) tick();
        for (int i = 0; i < 4; i++) begin
`ifdef QSPI_ARB_ROUND_ROBIN_EN
            sb.push_back(i % 2 == 0 ? ed : ei);
`else
            sb.push_back(ed);
`endif
        end
        bus.data_write = 1'b0;
        bus.data_addr = 25'h1000004;
        bus.data_len = 2'd0;
        bus.instr_addr = 25'h0000100;
        bus.data_req = 1'b1;
        bus.instr_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_done(200, ok);
            if (i == 3) begin
                bus.data_req = 1'b0;
                bus.instr_req = 1'b0;
            end
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL tie_timeout: grant %0d never completed", i);
            end else begin
                e = sb.pop_front();
                o = obs.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL tie_grant%0d: got data=%b rdata=%h sel%0d=%0d want data=%b rdata=%h sel%0d=%0d",
                             i, o.is_data, o.rdata, o.sel_id, o.sel_len, e.is_data, e.rdata, e.sel_id, e.sel_len);
                end
            end
        end
        bus.data_req = 1'b0;
        bus.instr_req = 1'b0;
        repeat (60) tick();
        n_checks++;
        if (obs.size() != 0) begin
            n_fail++;
            $display("FAIL tie_extra: got %0d completions after release want 0", obs.size());
        end
        obs.delete();
        sb.delete();
    endtask

    task automatic test_reset_mid();
        bit ok;
        txn_t e, o;
        repeat (3) tick();
        bus.data_write = 1'b0;
        bus.data_addr = 25'h1000020;
        bus.data_len = 2'd1;
        bus.data_req = 1'b1;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            ok = bus.qspi_ram_a_select === 1'b0;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL midrst_start: ram_a_select never went low");
        end
        repeat (9) tick();
        rst_n = 1'b0;
        bus.data_req = 1'b0;
        bus.latency_cfg = 3'd1;
        tick();
        n_checks++;
        if ({bus.qspi_flash_select, bus.qspi_ram_a_select, bus.qspi_ram_b_select, bus.qspi_data_oe, bus.qspi_clk_out} !== 8'b11100000) begin
            n_fail++;
            $display("FAIL midrst_pins: sel=%b oe=%h clk=%b want sel=111 oe=0 clk=0",
                     {bus.qspi_flash_select, bus.qspi_ram_a_select, bus.qspi_ram_b_select}, bus.qspi_data_oe, bus.qspi_clk_out);
        end
        tick();
        rst_n = 1'b1;
        bus.latency_cfg = 3'd5;
        rd_lat = 1;
        repeat (2) tick();
        n_checks++;
        if (obs.size() != 0) begin
            n_fail++;
            $display("FAIL midrst_done: got %0d completions for the aborted read want 0", obs.size());
        end
        obs.delete();
        sb.push_back('{is_data: 1'b1, err: 1'b0, rdata: 32'h3412, sel_len: 8'd37, sel_id: 2'd1});
        bus.data_req = 1'b1;
        wait_done(200, ok);
        bus.data_req = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL midrst_timeout: read after reset never completed");
        end else begin
            e = sb.pop_front();
            o = obs.pop_front();
            if (o !== e) begin
                n_fail++;
                $display("FAIL midrst_txn: got data=%b rdata=%h sel%0d=%0d want data=%b rdata=%h sel%0d=%0d",
                         o.is_data, o.rdata, o.sel_id, o.sel_len, e.is_data, e.rdata, e.sel_id, e.sel_len);
            end
        end
    endtask

    initial begin
        bus.latency_cfg = 3'd3;
        bus.instr_req = 1'b0;
        bus.instr_addr = 25'h0;
        bus.data_req = 1'b0;
        bus.data_write = 1'b0;
        bus.data_addr = 25'h0;
        bus.data_len = 2'd0;
        bus.data_wdata = 32'h0;
        bus.qspi_data_in = 4'h5;
        rd_nib = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'h8, 4'h9};
        rd_lat = 3;
        test_reset();
        test_fetch();
        test_drop();
        test_write();
        test_flash_write();
        test_tie();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
